bus_master: RTL and testbench
=============================

# bus_master

Initiator for the single-outstanding req/ack memory-bus handshake answered by the team's slave models. It accepts one transaction at a time from a valid/ready command port, drives `req`/`cmd`/`addr`/`wdata` until `ack`, captures `rdata` on reads, and returns the result on a valid/ready response port. A timeout watchdog and a completed-transaction counter support test benches and simple SoC bring-up.

## Interface
- `TIMEOUT`, 16: max cycles `req` is held high waiting for `ack` before the transaction is aborted (≥2).
- `MIN_GAP`, 1: min cycles `req` stays low between consecutive bus transactions (≥1).
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready`.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  32  transaction address.
- `cmd_wdata`  in  32  write data (ignored for reads).
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed when `rsp_valid & rsp_ready`.
- `rsp_rdata`  out  32  read data; 0 for writes and errors.
- `rsp_error`  out  1  1 = transaction timed out.
- `req`  out  1  bus request.
- `cmd`  out  1  bus command: 0 = read, 1 = write.
- `addr`  out  32  bus address.
- `wdata`  out  32  bus write data.
- `ack`  in  1  slave acknowledge, single-cycle pulse.
- `rdata`  in  32  slave read data, valid in the cycle `ack` = 1.
- `txn_count`  out  16  completed transactions (error-free), wraps.

## Operation
- States: IDLE, REQ, RESP, GAP.
- IDLE: `cmd_ready` = 1 only here. On accept, latch write/addr/wdata into `cmd`/`addr`/`wdata`, clear timeout counter, go REQ.
- REQ: `req` = 1, bus outputs stable. Each cycle, timeout counter increments (saturating).
  - `ack` = 1 sampled: for reads, `rsp_rdata` <= `rdata`; for writes, `rsp_rdata` <= 0. `rsp_error` <= 0, `txn_count` += 1 (wraps 0xFFFF→0x0000), go RESP.
  - No `ack` and counter reaches `TIMEOUT`-1: `rsp_rdata` <= 0, `rsp_error` <= 1, `txn_count` unchanged, go RESP.
  - `ack` and timeout in the same cycle: `ack` wins (success).
- RESP: `req` = 0, `rsp_valid` = 1, response fields held stable. On `rsp_valid & rsp_ready`, go GAP with the gap counter cleared.
- GAP: `req` = 0 for `MIN_GAP` cycles total, counted from the first cycle `req` is low. Then go IDLE. If the RESP stay already lasted ≥ `MIN_GAP` cycles, go straight from RESP to IDLE.
- `ack` seen outside REQ: ignored; no state change, no counter change.
- `cmd`/`addr`/`wdata` keep their last values after `req` drops. They change only on command accept.

## Timing
- Reset values (one edge with `rst` = 1, from any state including mid-REQ): state IDLE, `req` 0, `cmd` 0, `addr` 0, `wdata` 0, `cmd_ready` 1 after reset, `rsp_valid` 0, `rsp_rdata` 0, `rsp_error` 0, `txn_count` 0, internal counters 0. A reset during REQ drops `req` on the next edge with no response.
- All outputs are registered. `cmd_ready` is decoded from the state register.
- Accept at edge N → `req` = 1 from edge N to edge N+1 onward.
- `ack` = 1 sampled at edge M → `req` = 0 and `rsp_valid` = 1 after edge M. `req` is therefore never high in the cycle after `ack`, so the slave returns to idle without re-triggering.
- Best-case command-to-command throughput with a 1-cycle-ack slave and `rsp_ready` tied high: accept, REQ(1), RESP(1), IDLE accept = one transaction every 3 cycles.
- Timeout: `req` is high for exactly `TIMEOUT` cycles, then `rsp_valid` rises.

## Test plan
- Read: accept `cmd_write`=0, `addr`=0x10; slave acks 1 cycle after `req` with `rdata`=0x0000_0005 → `rsp_valid` next cycle, `rsp_rdata`=0x5, `rsp_error`=0, `txn_count`=1, `req` low in the cycle after `ack`.
- Write: `cmd_write`=1, `addr`=0x20, `wdata`=0xDEADBEEF → bus shows `cmd`=1, `addr`=0x20, `wdata`=0xDEADBEEF while `req`=1; response `rsp_rdata`=0, `rsp_error`=0.
- Timeout: `TIMEOUT`=16, slave never acks → `req` high exactly 16 cycles; `rsp_error`=1, `rsp_rdata`=0, `txn_count` unchanged. An `ack` on the same cycle as the 16th → success instead.
- Backpressure: hold `rsp_ready`=0 for 5 cycles → `rsp_valid` and data stable, `cmd_ready`=0, `req`=0; release → IDLE (gap already met), next command accepted.
- Reset mid-REQ: assert `rst` for 1 cycle while `req`=1 → all outputs at reset values after that edge, no `rsp_valid`; a later `ack` pulse is ignored.
- Wrap: preload with 65535 back-to-back successful reads, then one more → `txn_count` = 0x0000; `req` gap ≥ `MIN_GAP` between every pair.

Source files
------------

// File: rtl/bus_master_if.sv
// Command, response and memory-bus signals of the single-outstanding req/ack initiator.
interface bus_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        req;
    logic        cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, ack, rdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_error, req, cmd, addr, wdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, ack, rdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_error, req, cmd, addr, wdata
    );
endinterface

// File: rtl/bus_master.sv
// Single-outstanding req/ack bus initiator with timeout watchdog and
// completed-transaction counter. All outputs come straight from flops.
module bus_master #(
    parameter int TIMEOUT = 16,
    parameter int MIN_GAP = 1
) (
    input  logic          clk,
    input  logic          rst,
    bus_master_if.master  bus,
    output logic [15:0]   txn_count
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(MIN_GAP + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    logic [1:0]    state_q, state_d;
    logic          req_q, req_d;
    logic          cmd_q, cmd_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic          rsp_error_q, rsp_error_d;
    logic [15:0]   txn_count_q, txn_count_d;
    logic [TW-1:0] tmo_q, tmo_d;
    // gap_q counts req-low cycles already elapsed since req dropped
    logic [GW-1:0] gap_q, gap_d;
    logic          gap_met;

    // Current cycle completes the minimum req-low interval.
    assign gap_met = (int'(gap_q) + 1) >= MIN_GAP;

    // Next-state and datapath updates for the transaction FSM
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;
        txn_count_d = txn_count_q;
        tmo_d       = tmo_q;
        gap_d       = gap_q;
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    cmd_d   = bus.cmd_write;
                    addr_d  = bus.cmd_addr;
                    wdata_d = bus.cmd_wdata;
                    tmo_d   = '0;
                    req_d   = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (int'(tmo_q) < TIMEOUT) tmo_d = tmo_q + 1'b1;
                // ack takes priority over a timeout in the same cycle
                if (bus.ack) begin
                    rsp_rdata_d = cmd_q ? 32'h0 : bus.rdata;
                    rsp_error_d = 1'b0;
                    txn_count_d = txn_count_q + 16'd1;
                    rsp_valid_d = 1'b1;
                    req_d       = 1'b0;
                    gap_d       = '0;
                    state_d     = S_RESP;
                end else if (tmo_q == TMO_LAST) begin
                    rsp_rdata_d = 32'h0;
                    rsp_error_d = 1'b1;
                    rsp_valid_d = 1'b1;
                    req_d       = 1'b0;
                    gap_d       = '0;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (int'(gap_q) < MIN_GAP) gap_d = gap_q + 1'b1;
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = gap_met ? S_IDLE : S_GAP;
                end
            end
            default: begin
                if (int'(gap_q) < MIN_GAP) gap_d = gap_q + 1'b1;
                if (gap_met) state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            req_q       <= 1'b0;
            cmd_q       <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_error_q <= 1'b0;
            txn_count_q <= 16'h0;
            tmo_q       <= '0;
            gap_q       <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
            txn_count_q <= txn_count_d;
            tmo_q       <= tmo_d;
            gap_q       <= gap_d;
        end
    end

    assign bus.cmd_ready = (state_q == S_IDLE);
    assign bus.req       = req_q;
    assign bus.cmd       = cmd_q;
    assign bus.addr      = addr_q;
    assign bus.wdata     = wdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_error = rsp_error_q;
    assign txn_count     = txn_count_q;
endmodule

// File: tb/tb_bus_master.sv
// Scoreboard bench for bus_master: the bench acts as command source,
// response sink and slave, and predicts every response when it issues it.
module tb_bus_master;
    localparam int TIMEOUT = 16;
    localparam int MIN_GAP = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] txn_count;

    bus_master_if bif ();

    bus_master #(.TIMEOUT(TIMEOUT), .MIN_GAP(MIN_GAP)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bif),
        .txn_count (txn_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] exp_cnt = 16'h0;
    int          low_cnt = MIN_GAP;
    logic        req_prev = 1'b0;
    bit          mon_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // req must stay low at least MIN_GAP cycles before each new request
    always @(negedge clk) begin
        if (mon_en && bif.req === 1'b1 && req_prev === 1'b0)
            chk("req_gap", 32'(low_cnt >= MIN_GAP), 32'd1);
        if (bif.req === 1'b1) low_cnt <= 0;
        else                  low_cnt <= low_cnt + 1;
        req_prev <= bif.req;
    end

    // One full transaction; ack_at = index of req-high cycle carrying ack (-1 = never)
    task automatic do_txn(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input int ack_at, input int hold,
                          input bit chk_bus);
        rsp_t e;
        rsp_t got;
        int   hc;
        int   w;
        bit   ok;
        ok      = (ack_at >= 0) && (ack_at < TIMEOUT);
        e.rdata = (ok && !wr) ? rd : 32'h0;
        e.err   = !ok;
        if (ok) exp_cnt = exp_cnt + 16'd1;
        sb.push_back(e);

        bif.cmd_valid = 1'b1;
        bif.cmd_write = wr;
        bif.cmd_addr  = a;
        bif.cmd_wdata = wd;
        w = 0;
        while (bif.cmd_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) chk("cmd_ready_wait", {31'h0, bif.cmd_ready}, 32'd1);
        @(negedge clk);
        bif.cmd_valid = 1'b0;
        if (chk_bus) begin
            chk("bus_req", {31'h0, bif.req}, 32'd1);
            chk("bus_cmd", {31'h0, bif.cmd}, {31'h0, wr});
            chk("bus_addr", bif.addr, a);
            chk("bus_wdata", bif.wdata, wd);
        end

        hc = 0;
        while (bif.req === 1'b1 && hc < TIMEOUT + 4) begin
            bif.ack   = (hc == ack_at);
            bif.rdata = bif.ack ? rd : (32'hBAD0_0000 | 32'(hc));
            @(negedge clk);
            bif.ack = 1'b0;
            hc++;
        end
        chk("req_high_cycles", 32'(hc), ok ? 32'(ack_at + 1) : 32'(TIMEOUT));
        chk("rsp_valid_rise", {31'h0, bif.rsp_valid}, 32'd1);
        chk("req_after_done", {31'h0, bif.req}, 32'd0);

        if (hold > 0) begin
            bif.rsp_ready = 1'b0;
            repeat (hold) begin
                @(negedge clk);
                chk("bp_rsp_valid", {31'h0, bif.rsp_valid}, 32'd1);
                chk("bp_cmd_ready", {31'h0, bif.cmd_ready}, 32'd0);
                chk("bp_req", {31'h0, bif.req}, 32'd0);
                chk("bp_rdata", bif.rsp_rdata, e.rdata);
            end
            bif.rsp_ready = 1'b1;
        end

        if (bif.rsp_valid === 1'b1 && sb.size() > 0) begin
            got = sb.pop_front();
            chk("rsp_rdata", bif.rsp_rdata, got.rdata);
            chk("rsp_error", {31'h0, bif.rsp_error}, {31'h0, got.err});
            chk("txn_count", {16'h0, txn_count}, {16'h0, exp_cnt});
        end else begin
            chk("rsp_present", {31'h0, bif.rsp_valid}, 32'd1);
        end
        @(negedge clk);
        chk("rsp_valid_drop", {31'h0, bif.rsp_valid}, 32'd0);
        chk("idle_ready", {31'h0, bif.cmd_ready}, 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        bif.cmd_valid = 1'b0;
        bif.cmd_write = 1'b0;
        bif.cmd_addr  = 32'h0;
        bif.cmd_wdata = 32'h0;
        bif.rsp_ready = 1'b1;
        bif.ack       = 1'b0;
        bif.rdata     = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_req", {31'h0, bif.req}, 32'd0);
        chk("rst_cmd_ready", {31'h0, bif.cmd_ready}, 32'd1);
        chk("rst_rsp_valid", {31'h0, bif.rsp_valid}, 32'd0);
        chk("rst_addr", bif.addr, 32'h0);
        chk("rst_txn_count", {16'h0, txn_count}, 32'h0);
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // read, write, timeout, ack on the last allowed cycle, delayed ack
        do_txn(1'b0, 32'h10, 32'h0, 32'h0000_0005, 0, 0, 1'b1);
        do_txn(1'b1, 32'h20, 32'hDEAD_BEEF, 32'h1111_2222, 0, 0, 1'b1);
        do_txn(1'b0, 32'h30, 32'h0, 32'h7777_7777, -1, 0, 1'b1);
        do_txn(1'b0, 32'h34, 32'h0, 32'hCAFE_F00D, TIMEOUT - 1, 0, 1'b0);
        do_txn(1'b0, 32'h38, 32'h0, 32'h0BAD_CAFE, 3, 0, 1'b0);
        // backpressure on the response port
        do_txn(1'b0, 32'h40, 32'h0, 32'h1234_5678, 0, 5, 1'b0);
        do_txn(1'b1, 32'h44, 32'h5555_AAAA, 32'h0, -1, 5, 1'b0);

        // reset while req is high
        bif.cmd_valid = 1'b1;
        bif.cmd_write = 1'b1;
        bif.cmd_addr  = 32'h88;
        bif.cmd_wdata = 32'h1234;
        @(negedge clk);
        bif.cmd_valid = 1'b0;
        chk("mid_req_up", {31'h0, bif.req}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 16'h0;
        chk("mid_rst_req", {31'h0, bif.req}, 32'd0);
        chk("mid_rst_rsp_valid", {31'h0, bif.rsp_valid}, 32'd0);
        chk("mid_rst_cmd", {31'h0, bif.cmd}, 32'd0);
        chk("mid_rst_addr", bif.addr, 32'h0);
        chk("mid_rst_wdata", bif.wdata, 32'h0);
        chk("mid_rst_count", {16'h0, txn_count}, 32'h0);
        chk("mid_rst_ready", {31'h0, bif.cmd_ready}, 32'd1);
        bif.ack   = 1'b1;
        bif.rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        bif.ack = 1'b0;
        chk("stray_ack_req", {31'h0, bif.req}, 32'd0);
        chk("stray_ack_rsp", {31'h0, bif.rsp_valid}, 32'd0);
        chk("stray_ack_count", {16'h0, txn_count}, 32'h0);
        chk("stray_ack_ready", {31'h0, bif.cmd_ready}, 32'd1);

        // back-to-back random reads
        for (int i = 0; i < 8; i++) begin
            logic [31:0] rv;
            rv = $urandom;
            do_txn(1'b0, 32'(i * 4), 32'h0, rv, int'($urandom_range(0, 2)), 0, 1'b0);
        end

        // counter wrap: preload near the top, then two more successes
        force dut.txn_count_q = 16'hFFFE;
        @(negedge clk);
        release dut.txn_count_q;
        exp_cnt = 16'hFFFE;
        chk("wrap_preload", {16'h0, txn_count}, 32'h0000_FFFE);
        do_txn(1'b0, 32'h100, 32'h0, 32'hA5A5_0001, 0, 0, 1'b0);
        do_txn(1'b0, 32'h104, 32'h0, 32'hA5A5_0002, 0, 0, 1'b0);
        chk("wrap_zero", {16'h0, txn_count}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
